uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised UART receiver: synchronises an asynchronous serial line, detects start bits with false-start rejection, deserialises DATA_W bits LSB-first, checks the stop bit and (optionally) parity, and presents each received word with a one-cycle valid strobe. Sits behind the board RX pin and feeds LED, display or command logic. It replaces fixed 8-bit, 9600-baud, LED-only receivers.

## Interface
- CLK_DIV, 5208, clocks per bit (50 MHz / 9600 baud); legal ≥ 4
- DATA_W, 8, data bits per frame; legal 5..9
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only when UART_RX_PARITY_EN is defined
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- rx_uart  input  1  asynchronous serial line, idle high
- rx_data  output  DATA_W  last good word, LSB = first data bit received
- rx_vld  output  1  one-cycle pulse; rx_data updated in the same cycle
- frame_err  output  1  one-cycle pulse; stop bit sampled low
- parity_err  output  1  one-cycle pulse; parity mismatch (constant 0 without macro)
- busy  output  1  high while the FSM is not in IDLE

## Operation
- Synchroniser: rx_uart goes through ff0 → ff1 → ff2, each reset to 1. All sampling uses ff1. Falling edge = (ff1==0 && ff2==1).
- Bit timer cnt0: width $clog2(CLK_DIV). It counts 0..CLK_DIV-1 in every non-IDLE state and wraps to 0. Its wrap advances the bit. Sample point: cnt0 == CLK_DIV/2-1 (integer division), written H-1 below.
- Bit counter: width $clog2(DATA_W+1). It indexes data bits 0..DATA_W-1.
- FSM states:
  - IDLE: on a falling edge go to START, with cnt0 = 0 and bit counter = 0. All other input is ignored.
  - START: at the sample point, if ff1 == 1 (false start, glitch) return to IDLE; no strobe is issued and rx_data is unchanged. Otherwise stay until cnt0 wraps, then go to DATA.
  - DATA: at the sample point, shift ff1 into bit [bit counter] of an internal shift register. On wrap, go to STOP after the last bit, or to PARITY if the macro is defined.
  - PARITY (macro only): at the sample point, compute the XOR of the data bits, the received parity bit and PARITY_ODD; a non-zero result sets the pending parity-error flag. On wrap, go to STOP.
  - STOP: at the sample point, judge the frame and return to IDLE in the same cycle. Exit is half a bit early so back-to-back frames are not missed.
- Stop judgement, registered and applied in the next cycle:
  - stop = 1 and no parity error: rx_data ← shift register; pulse rx_vld.
  - stop = 0: pulse frame_err only; rx_data is held.
  - stop = 1 with parity error: pulse parity_err only; rx_data is held.
  - stop = 0 with parity error: pulse both frame_err and parity_err.
- Falling edges while busy are ignored. A line held low (break) cannot retrigger until it returns high and falls again.
- Asserting rst_n mid-frame aborts immediately. No strobe is issued and the partial word is discarded.

## Timing
- Reset values:
  - rx_data = 0, rx_vld = 0, frame_err = 0, parity_err = 0, busy = 0.
  - FSM = IDLE, counters = 0.
  - Synchroniser flops = 1.
- Let k be the clock edge at which a low rx_uart is first captured into ff0.
  - Edge detection occurs at k+1.
  - From k+2: busy = 1, START, cnt0 = 0.
- Let P = 1 with the macro, 0 without.
  - Stop sample cycle: S = k+2 + (1+DATA_W+P)·CLK_DIV + H-1.
  - Strobes and the rx_data update appear at S+1.
  - busy falls at S+1.
- Defaults without the macro: rx_vld at k + 49478.
- Earliest accepted next start: a falling edge detected at S+1.

## Configuration
- UART_RX_PARITY_EN defined:
  - A parity bit follows the data bits and the PARITY state exists.
  - PARITY_ODD selects even or odd parity.
  - parity_err is live.
- UART_RX_PARITY_EN undefined:
  - Frame is start + DATA_W + stop.
  - No PARITY state and no parity logic.
  - parity_err is tied to 0.

## Test plan
- CLK_DIV=16, DATA_W=8, no macro; send 0xA5 with 1 stop bit → rx_data = 0xA5 with one rx_vld pulse at exactly S+1; frame_err = 0.
- Send 0x3C and 0xC3 back-to-back with no idle gap → two rx_vld pulses, with rx_data 0x3C then 0xC3.
- Drive a 4-cycle low glitch (shorter than H) → no strobes; busy returns to 0 after the START sample; rx_data is unchanged.
- Send 0x55 with the stop bit forced low → frame_err pulses once; rx_vld = 0; rx_data holds its previous value. A following good frame 0x0F is received correctly.
- Macro defined, PARITY_ODD=0; send 0x07 with parity 1 → rx_vld. Resend 0x07 with parity 0 → parity_err only; rx_data is unchanged.
- Assert rst_n low during data bit 4 of a frame → all outputs return to reset values immediately. A frame 0x81 sent after release is received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with false-start rejection
// Define UART_RX_PARITY_EN to add a parity bit, the PARITY state and a live parity_err.
module uart_rx_param #(
   parameter int CLK_DIV    = 5208,
   parameter int DATA_W     = 8,
   parameter int PARITY_ODD = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_uart,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_vld,
   output logic              frame_err,
   output logic              parity_err,
   output logic              busy
);

   localparam int CW = $clog2(CLK_DIV);
   localparam int BW = $clog2(DATA_W + 1);
   localparam int H  = CLK_DIV / 2;

   localparam logic [CW-1:0] SAMPLE_AT = CW'(H - 1);
   localparam logic [CW-1:0] WRAP_AT   = CW'(CLK_DIV - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);

   generate
      if (CLK_DIV < 4 || DATA_W < 5 || DATA_W > 9 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
         $error("uart_rx_param: illegal parameter value");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   state_t            state;
   state_t            nxt;
   logic              ff0;
   logic              ff1;
   logic              ff2;
   logic              fall;
   logic [CW-1:0]     cnt0;
   logic [BW-1:0]     bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic              sample;
   logic              wrap;
   logic              perr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff0 <= 1'b1;
         ff1 <= 1'b1;
         ff2 <= 1'b1;
      end else begin
         ff0 <= rx_uart;
         ff1 <= ff0;
         ff2 <= ff1;
      end
   end

   assign fall = ~ff1 & ff2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE: begin
            if (fall) nxt = S_START;
         end
         S_START: begin
            if (sample && ff1) begin
               nxt = S_IDLE;
            end else if (wrap) begin
               nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (wrap && bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
               nxt = S_PARITY;
`else
               nxt = S_STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (wrap) nxt = S_STOP;
         end
`endif
         S_STOP: begin
            // leave at mid stop bit so a back-to-back start edge is caught
            if (sample) nxt = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy   = (state != S_IDLE);
      sample = busy && (cnt0 == SAMPLE_AT);
      wrap   = busy && (cnt0 == WRAP_AT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0    <= '0;
         bit_cnt <= '0;
      end else if (state == S_IDLE || nxt == S_IDLE) begin
         cnt0    <= '0;
         bit_cnt <= '0;
      end else begin
         cnt0 <= wrap ? '0 : cnt0 + 1'b1;
         if (state == S_DATA && wrap) bit_cnt <= bit_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg <= '0;
      end else if (state == S_DATA && sample) begin
         for (int i = 0; i < DATA_W; i++) begin
            if (bit_cnt == BW'(i)) shreg[i] <= ff1;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_pend <= 1'b0;
      end else if (state == S_IDLE) begin
         par_pend <= 1'b0;
      end else if (state == S_PARITY && sample) begin
         par_pend <= ^{shreg, ff1, (PARITY_ODD != 0)};
      end
   end

   assign perr = par_pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_err <= 1'b0;
      end else begin
         parity_err <= (state == S_STOP) && sample && perr;
      end
   end
`else
   assign perr       = 1'b0;
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data   <= '0;
         rx_vld    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_vld    <= 1'b0;
         frame_err <= 1'b0;
         if (state == S_STOP && sample) begin
            frame_err <= ~ff1;
            if (ff1 && !perr) begin
               rx_data <= shreg;
               rx_vld  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - self-checking bench for uart_rx_param
// Frame-level model predicts strobe cycles, held data and busy windows; UART_RX_PARITY_EN selects parity tests.
module tb_uart_rx_param;
   localparam int DIV     = 16;
   localparam int DW      = 8;
   localparam int H       = DIV / 2;
   localparam int PAR_ODD = 0;
`ifdef UART_RX_PARITY_EN
   localparam int P   = 1;
   localparam int LAT = 170;
`else
   localparam int P   = 0;
   localparam int LAT = 154;
`endif

   logic          clk;
   logic          rst_n;
   logic          rx_line;
   logic [DW-1:0] rx_data;
   logic          rx_vld;
   logic          frame_err;
   logic          parity_err;
   logic          busy;

   uart_rx_param #(
      .CLK_DIV   (DIV),
      .DATA_W    (DW),
      .PARITY_ODD(PAR_ODD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_uart   (rx_line),
      .rx_data   (rx_data),
      .rx_vld    (rx_vld),
      .frame_err (frame_err),
      .parity_err(parity_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int            at;
      logic          vld;
      logic          fe;
      logic          pe;
      logic [DW-1:0] data;
   } ev_t;

   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;
   ev_t           ev_q[$];
   logic [DW-1:0] obs_q[$];
   logic [DW-1:0] model_data = '0;
   int            busy_from = 0;
   int            busy_to = 0;
   int            last_rst_cyc = 0;
   int            vld_cnt = 0;
   int            fe_cnt = 0;
   int            pe_cnt = 0;
   int            busy_cyc = 0;
   int            last_vld_cyc = -1;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic good_par(input logic [DW-1:0] d);
      return (^d) ^ (PAR_ODD != 0);
   endfunction

   always @(negedge clk) begin
      logic e_vld;
      logic e_fe;
      logic e_pe;
      logic e_busy;
      ev_t  ev;
      e_vld = 1'b0;
      e_fe  = 1'b0;
      e_pe  = 1'b0;
      if (!rst_n) begin
         ev_q.delete();
         model_data   = '0;
         last_rst_cyc = cyc;
      end else if (ev_q.size() != 0 && ev_q[0].at == cyc) begin
         ev    = ev_q.pop_front();
         e_vld = ev.vld;
         e_fe  = ev.fe;
         e_pe  = ev.pe;
         if (ev.vld) model_data = ev.data;
      end
      e_busy = rst_n && busy_from > last_rst_cyc && cyc >= busy_from && cyc < busy_to;
      chk("rx_vld", rx_vld, e_vld);
      chk("frame_err", frame_err, e_fe);
      chk("parity_err", parity_err, e_pe);
      chk("rx_data", rx_data, model_data);
      chk("busy", busy, e_busy);
      if (rx_vld === 1'b1) begin
         vld_cnt++;
         last_vld_cyc = cyc;
         obs_q.push_back(rx_data);
      end
      if (frame_err === 1'b1) fe_cnt++;
      if (parity_err === 1'b1) pe_cnt++;
      if (busy === 1'b1) busy_cyc++;
   end

   // Called just after a clock edge; returns just after a clock edge.
   task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stop,
                             input int gap, input int abort_bit, output int k);
      ev_t  ev;
      logic perr;
      int   s1;
      k    = cyc + 1;
      perr = (P != 0) && (((^d) ^ par ^ (PAR_ODD != 0)) != 1'b0);
      s1   = k + 2 + (1 + DW + P) * DIV + H;
      ev.at   = s1;
      ev.vld  = stop && !perr;
      ev.fe   = !stop;
      ev.pe   = perr;
      ev.data = d;
      ev_q.push_back(ev);
      busy_from = k + 2;
      busy_to   = s1;
      rx_line = 1'b0;
      repeat (DIV) @(posedge clk);
      #1;
      for (int i = 0; i < DW; i++) begin
         rx_line = d[i];
         if (i == abort_bit) begin
            repeat (5) @(posedge clk);
            #2;
            chk("abort_busy_before", busy, 1);
            rst_n = 1'b0;
            #1;
            chk("abort_rx_data", rx_data, 0);
            chk("abort_busy", busy, 0);
            chk("abort_strobes", {rx_vld, frame_err, parity_err}, 0);
            rx_line = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;
            return;
         end
         repeat (DIV) @(posedge clk);
         #1;
      end
      if (P != 0) begin
         rx_line = par;
         repeat (DIV) @(posedge clk);
         #1;
      end
      rx_line = stop;
      repeat (DIV) @(posedge clk);
      #1;
      rx_line = 1'b1;
      repeat (gap) @(posedge clk);
      #1;
   endtask

   task automatic send_glitch(input int len);
      int k;
      k         = cyc + 1;
      busy_from = k + 2;
      busy_to   = k + 2 + H;
      rx_line   = 1'b0;
      repeat (len) @(posedge clk);
      #1;
      rx_line = 1'b1;
      repeat (30) @(posedge clk);
      #1;
   endtask

   initial begin
      int k;
      int v0;
      int f0;
      int p0;
      int b0;
      rst_n   = 1'b0;
      rx_line = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rx_data", rx_data, 0);
      chk("reset_rx_vld", rx_vld, 0);
      chk("reset_frame_err", frame_err, 0);
      chk("reset_parity_err", parity_err, 0);
      chk("reset_busy", busy, 0);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      v0 = vld_cnt;
      f0 = fe_cnt;
      send_frame(8'hA5, good_par(8'hA5), 1'b1, 20, -1, k);
      chk("a5_count", vld_cnt - v0, 1);
      chk("a5_latency", last_vld_cyc - k, LAT);
      chk("a5_data", rx_data, 8'hA5);
      chk("a5_no_frame_err", fe_cnt - f0, 0);

      v0 = vld_cnt;
      send_frame(8'h3C, good_par(8'h3C), 1'b1, 0, -1, k);
      send_frame(8'hC3, good_par(8'hC3), 1'b1, 20, -1, k);
      chk("b2b_count", vld_cnt - v0, 2);
      if (obs_q.size() >= 2) begin
         chk("b2b_first", obs_q[obs_q.size()-2], 8'h3C);
         chk("b2b_second", obs_q[obs_q.size()-1], 8'hC3);
      end

      v0 = vld_cnt;
      f0 = fe_cnt;
      p0 = pe_cnt;
      b0 = busy_cyc;
      send_glitch(4);
      chk("glitch_strobes", (vld_cnt - v0) + (fe_cnt - f0) + (pe_cnt - p0), 0);
      chk("glitch_busy_cycles", busy_cyc - b0, 8);
      chk("glitch_idle", busy, 0);
      chk("glitch_data", rx_data, 8'hC3);

      v0 = vld_cnt;
      f0 = fe_cnt;
      send_frame(8'h55, good_par(8'h55), 1'b0, 20, -1, k);
      chk("ferr_count", fe_cnt - f0, 1);
      chk("ferr_no_vld", vld_cnt - v0, 0);
      chk("ferr_data_held", rx_data, 8'hC3);
      v0 = vld_cnt;
      send_frame(8'h0F, good_par(8'h0F), 1'b1, 20, -1, k);
      chk("after_ferr_count", vld_cnt - v0, 1);
      chk("after_ferr_data", rx_data, 8'h0F);

`ifdef UART_RX_PARITY_EN
      v0 = vld_cnt;
      p0 = pe_cnt;
      send_frame(8'h07, 1'b1, 1'b1, 20, -1, k);
      chk("par_ok_count", vld_cnt - v0, 1);
      chk("par_ok_no_perr", pe_cnt - p0, 0);
      chk("par_ok_data", rx_data, 8'h07);
      v0 = vld_cnt;
      f0 = fe_cnt;
      p0 = pe_cnt;
      send_frame(8'h07, 1'b0, 1'b1, 20, -1, k);
      chk("par_bad_perr", pe_cnt - p0, 1);
      chk("par_bad_no_vld", vld_cnt - v0, 0);
      chk("par_bad_no_ferr", fe_cnt - f0, 0);
      chk("par_bad_data_held", rx_data, 8'h07);
`endif

      v0 = vld_cnt;
      send_frame(8'h81, good_par(8'h81), 1'b1, 0, 4, k);
      repeat (10) @(posedge clk);
      #1;
      send_frame(8'h81, good_par(8'h81), 1'b1, 20, -1, k);
      chk("post_reset_count", vld_cnt - v0, 1);
      chk("post_reset_data", rx_data, 8'h81);
      chk("no_pending_events", ev_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
